// File: rtl/tedv3_descriptor_fetcher_if.sv
// Avalon-MM bus between the descriptor fetcher (master) and the descriptor memory (slave).
// The memory answers reads with a fixed latency of one cycle.
interface tedv3_descriptor_fetcher_if;
  logic [9:0]  m_address;
  logic        m_chipselect;
  logic        m_write;
  logic [3:0]  m_byteenable;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;

  modport master (
    output m_address, m_chipselect, m_write, m_byteenable, m_writedata,
    input  m_readdata
  );

  modport slave (
    input  m_address, m_chipselect, m_write, m_byteenable, m_writedata,
    output m_readdata
  );
endinterface

// File: rtl/tedv3_descriptor_fetcher.sv
// Walks a linked chain of 4-word descriptors, presents each on a valid/ready port,
// writes the DONE flag back into word 3 and follows the next-base pointer.
module tedv3_descriptor_fetcher #(
  parameter int MAX_DESC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic [9:0]  i_start_addr,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic [7:0]  o_desc_count,
  output logic        o_desc_valid,
  input  logic        i_desc_ready,
  output logic [31:0] o_desc_src,
  output logic [31:0] o_desc_dst,
  output logic [31:0] o_desc_len,
  output logic [31:0] o_desc_ctrl,
  tedv3_descriptor_fetcher_if.master m_bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_WAIT      = 3'd2,
    S_PRESENT   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_NEXT      = 3'd5,
    S_ERROR     = 3'd6
  } state_t;

  state_t      r_state;
  logic [9:0]  r_base;
  logic [1:0]  r_k;
  logic        r_busy;
  logic        r_done;
  logic        r_error;
  logic        r_desc_valid;
  logic [7:0]  r_desc_count;
  logic [31:0] r_desc_src;
  logic [31:0] r_desc_dst;
  logic [31:0] r_desc_len;
  logic [31:0] r_desc_ctrl;
  logic [9:0]  r_m_address;
  logic        r_m_chipselect;
  logic        r_m_write;
  logic [3:0]  r_m_byteenable;
  logic [31:0] r_m_writedata;

  logic [9:0]  w_next_base;
  logic        w_last;
  logic        w_at_max;
  logic [31:0] w_wb_data;
  logic [9:0]  w_fetch_addr;
  logic [7:0]  w_count_inc;

  assign w_next_base  = r_desc_ctrl[9:0];
  assign w_last       = r_desc_ctrl[31];
  assign w_at_max     = ({24'd0, r_desc_count} >= $unsigned(MAX_DESC));
  assign w_wb_data    = {r_desc_ctrl[31], 1'b1, r_desc_ctrl[29:0]};
  assign w_fetch_addr = r_base + {8'd0, r_k + 2'd1};
  assign w_count_inc  = (r_desc_count == 8'hFF) ? r_desc_count : r_desc_count + 8'd1;

  // Chain-walking state machine; every output is a register updated here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_base         <= 10'd0;
      r_k            <= 2'd0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_desc_valid   <= 1'b0;
      r_desc_count   <= 8'd0;
      r_desc_src     <= 32'd0;
      r_desc_dst     <= 32'd0;
      r_desc_len     <= 32'd0;
      r_desc_ctrl    <= 32'd0;
      r_m_address    <= 10'd0;
      r_m_chipselect <= 1'b0;
      r_m_write      <= 1'b0;
      r_m_byteenable <= 4'h0;
      r_m_writedata  <= 32'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_busy <= 1'b1;
            if (i_start_addr[1:0] == 2'b00) begin
              r_error        <= 1'b0;
              r_desc_count   <= 8'd0;
              r_base         <= i_start_addr;
              r_k            <= 2'd0;
              r_m_address    <= i_start_addr;
              r_m_chipselect <= 1'b1;
              r_m_byteenable <= 4'hF;
              r_state        <= S_FETCH;
            end else begin
              r_error <= 1'b1;
              r_state <= S_ERROR;
            end
          end
        end
        S_FETCH: begin
          // Read data trails its address by one cycle, so word k-1 arrives while k is on the bus.
          case (r_k)
            2'd1:    r_desc_src <= m_bus.m_readdata;
            2'd2:    r_desc_dst <= m_bus.m_readdata;
            2'd3:    r_desc_len <= m_bus.m_readdata;
            default: ;
          endcase
          if (r_k == 2'd3) begin
            r_m_chipselect <= 1'b0;
            r_m_byteenable <= 4'h0;
            r_state        <= S_WAIT;
          end else begin
            r_k         <= r_k + 2'd1;
            r_m_address <= w_fetch_addr;
          end
        end
        S_WAIT: begin
          r_desc_ctrl  <= m_bus.m_readdata;
          r_desc_valid <= 1'b1;
          r_state      <= S_PRESENT;
        end
        S_PRESENT: begin
          if (i_desc_ready) begin
            r_desc_valid   <= 1'b0;
            r_m_address    <= r_base + 10'd3;
            r_m_chipselect <= 1'b1;
            r_m_write      <= 1'b1;
            r_m_byteenable <= 4'hF;
            r_m_writedata  <= w_wb_data;
            r_state        <= S_WRITEBACK;
          end
        end
        S_WRITEBACK: begin
          r_m_chipselect <= 1'b0;
          r_m_write      <= 1'b0;
          r_m_byteenable <= 4'h0;
          r_m_writedata  <= 32'd0;
          r_desc_count   <= w_count_inc;
          r_state        <= S_NEXT;
        end
        S_NEXT: begin
          // LAST wins over the pointer checks; the count seen here already includes this descriptor.
          if (w_last) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if ((w_next_base[1:0] != 2'b00) || w_at_max) begin
            r_error <= 1'b1;
            r_state <= S_ERROR;
          end else begin
            r_base         <= w_next_base;
            r_k            <= 2'd0;
            r_m_address    <= w_next_base;
            r_m_chipselect <= 1'b1;
            r_m_byteenable <= 4'hF;
            r_state        <= S_FETCH;
          end
        end
        S_ERROR: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy         <= 1'b0;
          r_desc_valid   <= 1'b0;
          r_m_chipselect <= 1'b0;
          r_m_write      <= 1'b0;
          r_m_byteenable <= 4'h0;
          r_state        <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy              = r_busy;
  assign o_done              = r_done;
  assign o_error             = r_error;
  assign o_desc_count        = r_desc_count;
  assign o_desc_valid        = r_desc_valid;
  assign o_desc_src          = r_desc_src;
  assign o_desc_dst          = r_desc_dst;
  assign o_desc_len          = r_desc_len;
  assign o_desc_ctrl         = r_desc_ctrl;
  assign m_bus.m_address     = r_m_address;
  assign m_bus.m_chipselect  = r_m_chipselect;
  assign m_bus.m_write       = r_m_write;
  assign m_bus.m_byteenable  = r_m_byteenable;
  assign m_bus.m_writedata   = r_m_writedata;

endmodule

// File: tb/tb_tedv3_descriptor_fetcher.sv
// Scoreboard bench: a chain-walking reference model queues the expected bus reads, descriptors,
// writebacks and outcomes; an independent monitor pops and compares as the DUT produces them.
module tb_tedv3_descriptor_fetcher;
  localparam int TB_MAX = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_start = 1'b0;
  logic [9:0]  i_start_addr = 10'd0;
  logic        o_busy, o_done, o_error, o_desc_valid;
  logic        i_desc_ready = 1'b1;
  logic [7:0]  o_desc_count;
  logic [31:0] o_desc_src, o_desc_dst, o_desc_len, o_desc_ctrl;

  tedv3_descriptor_fetcher_if bus();

  tedv3_descriptor_fetcher #(.MAX_DESC(TB_MAX)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_start      (i_start),
    .i_start_addr (i_start_addr),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_error      (o_error),
    .o_desc_count (o_desc_count),
    .o_desc_valid (o_desc_valid),
    .i_desc_ready (i_desc_ready),
    .o_desc_src   (o_desc_src),
    .o_desc_dst   (o_desc_dst),
    .o_desc_len   (o_desc_len),
    .o_desc_ctrl  (o_desc_ctrl),
    .m_bus        (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_mode = 0;
  logic ready_force = 1'b1;
  int ref_count = 0;

  logic [31:0] mem [0:1023];
  logic [31:0] ref_mem [0:1023];

  logic [9:0]   q_rd[$];
  logic [127:0] q_desc[$];
  logic [41:0]  q_wb[$];
  logic [8:0]   q_out[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic wr_mem(input logic [9:0] a, input logic [31:0] d);
    mem[a] = d;
    ref_mem[a] = d;
  endtask

  // Reference: follow the chain through the model memory, applying writebacks as they happen.
  task automatic model_chain(input logic [9:0] sa);
    logic [9:0]  b;
    logic [31:0] w [4];
    int cnt;
    if (sa[1:0] != 2'b00) begin
      q_out.push_back({1'b1, 8'(ref_count)});
      return;
    end
    b = sa;
    cnt = 0;
    forever begin
      for (int k = 0; k < 4; k++) begin
        q_rd.push_back(b + 10'(k));
        w[k] = ref_mem[b + 10'(k)];
      end
      q_desc.push_back({w[0], w[1], w[2], w[3]});
      q_wb.push_back({b + 10'd3, w[3] | 32'h4000_0000});
      ref_mem[b + 10'd3] = w[3] | 32'h4000_0000;
      cnt = (cnt < 255) ? cnt + 1 : 255;
      if (w[3][31]) begin
        q_out.push_back({1'b0, 8'(cnt)});
        break;
      end
      if (w[3][1:0] != 2'b00 || cnt >= TB_MAX) begin
        q_out.push_back({1'b1, 8'(cnt)});
        break;
      end
      b = w[3][9:0];
    end
    ref_count = cnt;
  endtask

  task automatic run_chain(input logic [9:0] sa);
    bit ok;
    model_chain(sa);
    @(negedge clk);
    i_start = 1'b1;
    i_start_addr = sa;
    @(negedge clk);
    i_start = 1'b0;
    ok = 0;
    for (int i = 0; i < 4000; i++) begin
      if (!o_busy) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    chk("chain_finished", ok, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic load_desc(input logic [9:0] b, input logic [31:0] s, input logic [31:0] d,
                           input logic [31:0] l, input logic [31:0] c);
    wr_mem(b, s);
    wr_mem(b + 10'd1, d);
    wr_mem(b + 10'd2, l);
    wr_mem(b + 10'd3, c);
  endtask

  task automatic gen_chain(output logic [9:0] first);
    int n;
    int sel;
    bit dup;
    logic [9:0]  bases [5];
    logic [31:0] c;
    n = $urandom_range(1, 5);
    for (int i = 0; i < n; i++) begin
      do begin
        bases[i] = {8'($urandom_range(0, 255)), 2'b00};
        dup = 0;
        for (int j = 0; j < i; j++) if (bases[j] == bases[i]) dup = 1;
      end while (dup);
    end
    for (int i = 0; i < n; i++) begin
      c = {(i == n - 1), 1'b0, 20'($urandom), (i == n - 1) ? 10'($urandom) : bases[(i + 1) % 5]};
      sel = $urandom_range(0, 9);
      if (i < n - 1 && sel == 0) c[1:0] = 2'($urandom_range(1, 3));
      if (i < n - 1 && sel == 1) c[9:0] = bases[i];
      load_desc(bases[i], $urandom, $urandom, $urandom, c);
    end
    first = bases[0];
    if ($urandom_range(0, 9) == 0) first = first | 10'd2;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Descriptor memory with one-cycle read latency.
  initial begin
    bus.m_readdata = 32'd0;
    forever begin
      @(posedge clk);
      if (bus.m_chipselect && !bus.m_write) bus.m_readdata <= mem[bus.m_address];
      if (bus.m_chipselect && bus.m_write) mem[bus.m_address] = bus.m_writedata;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       i_desc_ready = 1'b1;
        1:       i_desc_ready = 1'($urandom_range(0, 1));
        default: i_desc_ready = ready_force;
      endcase
    end
  end

  // Monitor: all scoreboard comparisons against live DUT activity.
  initial begin
    logic prev_busy, prev_hold, prev_hs, saw_first;
    logic [127:0] held, exp_d;
    logic [41:0]  exp_w;
    logic [8:0]   exp_o;
    int t_start;
    prev_busy = 0; prev_hold = 0; prev_hs = 0; saw_first = 1; t_start = 0; held = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_busy = 0; prev_hold = 0; prev_hs = 0; saw_first = 1;
      end else begin
        if (bus.m_chipselect) chk("byteenable_when_cs", bus.m_byteenable, 4'hF);
        if (bus.m_chipselect && !bus.m_write) begin
          chk("read_expected", q_rd.size() > 0, 1'b1);
          if (q_rd.size() > 0) chk("read_addr", bus.m_address, q_rd.pop_front());
        end
        if (prev_hs) chk("writeback_after_handshake", bus.m_chipselect && bus.m_write, 1'b1);
        if (bus.m_chipselect && bus.m_write) begin
          chk("writeback_expected", q_wb.size() > 0, 1'b1);
          if (q_wb.size() > 0) begin
            exp_w = q_wb.pop_front();
            chk("writeback_addr_data", {bus.m_address, bus.m_writedata}, exp_w);
          end
        end
        if (!prev_busy && o_busy) begin
          t_start = cyc - 1;
          saw_first = 0;
        end
        if (o_desc_valid) begin
          chk("no_bus_while_presenting", bus.m_chipselect, 1'b0);
          if (!saw_first) begin
            chk("first_valid_latency", cyc - t_start, 6);
            saw_first = 1;
          end
          if (prev_hold) chk("desc_stable", {o_desc_src, o_desc_dst, o_desc_len, o_desc_ctrl}, held);
          if (i_desc_ready) begin
            chk("desc_expected", q_desc.size() > 0, 1'b1);
            if (q_desc.size() > 0) begin
              exp_d = q_desc.pop_front();
              chk("desc_words", {o_desc_src, o_desc_dst, o_desc_len, o_desc_ctrl}, exp_d);
            end
          end
        end
        prev_hold = o_desc_valid && !i_desc_ready;
        prev_hs   = o_desc_valid && i_desc_ready;
        held      = {o_desc_src, o_desc_dst, o_desc_len, o_desc_ctrl};
        if (prev_busy && !o_busy) begin
          chk("outcome_expected", q_out.size() > 0, 1'b1);
          if (q_out.size() > 0) begin
            exp_o = q_out.pop_front();
            chk("error_flag", o_error, exp_o[8]);
            chk("desc_count", o_desc_count, exp_o[7:0]);
            chk("done_pulse", o_done, !exp_o[8]);
          end
        end else begin
          chk("done_low", o_done, 1'b0);
        end
        prev_busy = o_busy;
      end
    end
  end

  initial begin
    logic [9:0] sa;
    for (int i = 0; i < 1024; i++) wr_mem(10'(i), 32'd0);
    repeat (3) @(negedge clk);
    chk("reset_ctrl_outputs", {o_busy, o_done, o_error, o_desc_valid, o_desc_count, bus.m_address,
        bus.m_chipselect, bus.m_write, bus.m_byteenable, bus.m_writedata}, 128'd0);
    chk("reset_desc_outputs", {o_desc_src, o_desc_dst, o_desc_len, o_desc_ctrl}, 128'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single descriptor with LAST.
    load_desc(10'd0, 32'hAAAA_0001, 32'hBBBB_0002, 32'h0000_0040, 32'h8000_0000);
    run_chain(10'd0);
    chk("single_mem3_writeback", mem[3], 32'hC000_0000);
    chk("single_count", o_desc_count, 8'd1);

    // Three-descriptor chain 0 -> 8 -> 16.
    load_desc(10'd0,  32'h1, 32'h2, 32'h3, 32'h0000_0008);
    load_desc(10'd8,  32'h4, 32'h5, 32'h6, 32'h0000_0010);
    load_desc(10'd16, 32'h7, 32'h8, 32'h9, 32'h8000_0000);
    run_chain(10'd0);
    chk("chain3_count", o_desc_count, 8'd3);

    // Backpressure: ready low for 10 cycles while presenting.
    load_desc(10'd40, 32'h1111, 32'h2222, 32'h3333, 32'h8000_0000);
    ready_force = 1'b0;
    ready_mode = 2;
    fork
      run_chain(10'd40);
      begin
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (o_desc_valid) break;
        end
        chk("bp_valid_seen", o_desc_valid, 1'b1);
        repeat (10) @(negedge clk);
        ready_force = 1'b1;
      end
    join
    ready_mode = 0;

    // Faults: misaligned start, misaligned next pointer, self-loop to MAX.
    run_chain(10'd5);
    chk("misaligned_start_error", o_error, 1'b1);
    load_desc(10'd0, 32'h10, 32'h20, 32'h30, 32'h0000_0006);
    run_chain(10'd0);
    chk("bad_next_count", o_desc_count, 8'd1);
    load_desc(10'd32, 32'h5A, 32'hA5, 32'h77, 32'h0000_0020);
    run_chain(10'd32);
    chk("selfloop_error", o_error, 1'b1);
    chk("selfloop_count", o_desc_count, 8'd4);

    // Reset during the second fetch cycle, then a clean restart.
    load_desc(10'd0, 32'hCAFE, 32'hF00D, 32'h80, 32'h8000_0000);
    model_chain(10'd0);
    @(negedge clk);
    i_start = 1'b1;
    i_start_addr = 10'd0;
    @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    chk("fetch2_addr", {bus.m_chipselect, bus.m_address}, {1'b1, 10'd1});
    reset = 1'b1;
    #1;
    chk("midrun_reset_ctrl", {o_busy, o_done, o_error, o_desc_valid, o_desc_count, bus.m_address,
        bus.m_chipselect, bus.m_write, bus.m_byteenable, bus.m_writedata}, 128'd0);
    chk("midrun_reset_desc", {o_desc_src, o_desc_dst, o_desc_len, o_desc_ctrl}, 128'd0);
    q_rd.delete(); q_desc.delete(); q_wb.delete(); q_out.delete();
    load_desc(10'd0, 32'hCAFE, 32'hF00D, 32'h80, 32'h8000_0000);
    ref_count = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_chain(10'd0);
    chk("after_reset_count", o_desc_count, 8'd1);

    // Start pulsed while busy must be ignored.
    load_desc(10'd64, 32'h61, 32'h62, 32'h63, 32'h0000_0048);
    load_desc(10'd72, 32'h71, 32'h72, 32'h73, 32'h8000_0000);
    load_desc(10'd128, 32'hDEAD, 32'hBEEF, 32'h1, 32'h8000_0000);
    fork
      run_chain(10'd64);
      begin
        repeat (3) @(negedge clk);
        i_start = 1'b1;
        i_start_addr = 10'd128;
        @(negedge clk);
        i_start = 1'b0;
      end
    join
    chk("busy_start_count", o_desc_count, 8'd2);

    // Randomized chains with random backpressure.
    ready_mode = 1;
    for (int t = 0; t < 30; t++) begin
      gen_chain(sa);
      run_chain(sa);
    end
    ready_mode = 0;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", q_rd.size() + q_desc.size() + q_wb.size() + q_out.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
